pwm_audio_dac: RTL and testbench
================================

# pwm_audio_dac

Mono PWM audio modulator that drives the board amplifier's PWM input. The amplifier's shutdown pins are held permanently enabled elsewhere in the audio path. This block accepts stereo signed PCM samples through a valid/ready handshake and mixes them to mono. It converts the result to a glitch-free, fixed-carrier PWM duty cycle. A soft start/stop ramp suppresses pops when the amplifier is muted or unmuted.

## Interface
- SAMPLE_W, 16, width of each signed input sample (two's complement)
- PWM_BITS, 8, carrier resolution; carrier period = 2^PWM_BITS clocks; MID = 2^(PWM_BITS-1)
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- l_i  input  SAMPLE_W  left sample, signed
- r_i  input  SAMPLE_W  right sample, signed
- sample_valid  input  1  l_i/r_i valid this cycle
- sample_ready  output  1  holding register empty; transfer on sample_valid & sample_ready
- mute  input  1  1 = ramp output down to silence-off; 0 = ramp up and play
- pwm_o  output  1  registered PWM bit (1 = release/high, top level maps to open-drain)
- active  output  1  state is RUN
- underrun  output  1  one-cycle pulse: RUN wrap with empty holding register

## Operation
- Reset values:
  - cnt=0, duty=0, ramp=0, state=OFF, full=0.
  - pwm_o=0, active=0, underrun=0.
  - sample_ready=0 while reset is high, then 1 on the first cycle after reset.
- Mix: sum = sext(l_i)+sext(r_i) at SAMPLE_W+1 bits; mixed = sum arithmetic >>1, truncated to SAMPLE_W (cannot overflow).
- Offset binary: invert MSB of mixed; sdut = top PWM_BITS bits. The computation is done at accept time and sdut is stored in the holding register.
- Holding register:
  - full set on accept; sample_ready = !full.
  - full cleared at every wrap, in any state; in non-RUN states the sample is discarded so the source never stalls.
  - Accept on the same cycle as a wrap with full=0: the sample is stored and full=1 after that cycle. The sample is consumed at the next wrap.
- Carrier: cnt free-runs 0..2^PWM_BITS-1. The wrap cycle is cnt==max. duty, ramp and state change only on wrap cycles.
- pwm_o <= (cnt < duty). The maximum duty is 2^PWM_BITS-1, so the output is never 100% high. duty=0 gives constant 0.
- State machine (evaluated on wrap cycles only):
  - OFF: duty=0. If mute=0: go to RAMP_UP, ramp=0.
  - RAMP_UP: if mute=1: go to RAMP_DOWN. Else if ramp==MID: go to RUN, duty=MID. Else ramp+1, duty=ramp+1.
  - RUN: if mute=1: go to RAMP_DOWN, ramp=duty. Else if full: duty=sdut. Else duty unchanged and underrun pulses for 1 cycle.
  - RAMP_DOWN: if ramp==0: go to OFF. Else ramp-1, duty=ramp-1. A mute deassert has no effect until OFF is reached.
- active = (state==RUN), registered along with the state.

## Timing
- Accept-to-duty latency: a sample takes effect at the first wrap after acceptance, which is at most 2^PWM_BITS clocks. pwm_o then reflects the new duty one clock after the wrap, in the period beginning at cnt=0.
- pwm_o has exactly 1 clock of latency from cnt/duty.
- Duty changes only at period boundaries, so no partial or runt pulses occur.
- Ramp up from OFF: MID+1 wraps (about (MID+1)*2^PWM_BITS clocks) until active=1.
- Ramp down from duty d: d+1 wraps until OFF.
- Reset mid-operation: on the next edge every register returns to its reset value, pwm_o=0 and the stored sample is lost.
- sample_valid with sample_ready=0: no transfer, and the inputs are ignored.

## Test plan
- Reset then mute=0 (defaults): duty rises 1,2,...,128 per wrap. active=1 after 129 wraps. pwm_o high for exactly 128 of 256 clocks per period.
- In RUN, feed l=r=0x7FFF -> duty 255 (pwm_o high 255/256). Feed l=r=0x8000 -> duty 0. Feed l=0x7FFF, r=0x8000 -> duty 127.
- In RUN, feed one sample and then none: the duty holds its last value and underrun pulses one cycle at each subsequent wrap.
- Handshake: valid held high continuously -> one transfer per period, sample_ready low between accept and wrap. An accept on the wrap cycle is consumed at the next wrap, not the current one.
- mute=1 in RUN at duty 200: duty decrements 199..0 over successive wraps, then OFF with pwm_o constant 0. mute=0 mid-ramp-down -> ramp continues to OFF, then ramps up again.
- Assert reset for 1 cycle during RUN with full=1: next cycle pwm_o=0, active=0, sample_ready=1 after reset release, state OFF.

Source files
------------

// File: rtl/pwm_audio_dac.sv
// Mono PWM audio modulator: stereo PCM in over valid/ready, mixed to mono,
// fixed-carrier PWM out with a soft start/stop ramp around mute.
module pwm_audio_dac #(
    parameter int SAMPLE_W = 16,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] l_i,
    input  logic [SAMPLE_W-1:0] r_i,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                mute,
    output logic                pwm_o,
    output logic                active,
    output logic                underrun
);
    localparam logic [PWM_BITS-1:0] MID     = {1'b1, {(PWM_BITS-1){1'b0}}};
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {OFF, RAMP_UP, RUN, RAMP_DOWN} state_t;

    state_t              state;
    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] ramp;
    logic [PWM_BITS-1:0] sdut;
    logic                full;

    logic [SAMPLE_W:0]   sum;
    logic [SAMPLE_W-1:0] mixed;
    logic [SAMPLE_W-1:0] offset;
    logic [PWM_BITS-1:0] sdut_next;
    logic                wrap;
    logic                accept;
    logic                unused_bits;

    // Halving the one-bit-wider sum keeps the mix in range without saturation.
    assign sum       = {l_i[SAMPLE_W-1], l_i} + {r_i[SAMPLE_W-1], r_i};
    assign mixed     = sum[SAMPLE_W:1];
    assign offset    = {~mixed[SAMPLE_W-1], mixed[SAMPLE_W-2:0]};
    assign sdut_next = offset[SAMPLE_W-1 -: PWM_BITS];
    assign unused_bits = ^{sum[0], offset[SAMPLE_W-PWM_BITS-1:0]};

    assign sample_ready = !full && !reset;
    assign accept       = sample_valid && sample_ready;
    assign wrap         = (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            duty     <= '0;
            ramp     <= '0;
            sdut     <= '0;
            full     <= 1'b0;
            state    <= OFF;
            pwm_o    <= 1'b0;
            active   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            cnt      <= cnt + 1'b1;
            pwm_o    <= (cnt < duty);
            underrun <= 1'b0;
            if (accept)
                sdut <= sdut_next;
            // Every wrap empties the holding register; a same-cycle accept refills it.
            full <= accept | (full & ~wrap);
            if (wrap) begin
                case (state)
                    OFF: begin
                        duty <= '0;
                        if (!mute) begin
                            state <= RAMP_UP;
                            ramp  <= '0;
                        end
                    end
                    RAMP_UP: begin
                        if (mute) begin
                            state <= RAMP_DOWN;
                        end else if (ramp == MID) begin
                            state  <= RUN;
                            duty   <= MID;
                            active <= 1'b1;
                        end else begin
                            ramp <= ramp + 1'b1;
                            duty <= ramp + 1'b1;
                        end
                    end
                    RUN: begin
                        if (mute) begin
                            state  <= RAMP_DOWN;
                            ramp   <= duty;
                            active <= 1'b0;
                        end else if (full) begin
                            duty <= sdut;
                        end else begin
                            underrun <= 1'b1;
                        end
                    end
                    RAMP_DOWN: begin
                        // Unmute is deliberately ignored until the ramp bottoms out.
                        if (ramp == '0) begin
                            state <= OFF;
                            duty  <= '0;
                        end else begin
                            ramp <= ramp - 1'b1;
                            duty <= ramp - 1'b1;
                        end
                    end
                    default: state <= OFF;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pwm_audio_dac.sv
// Directed bench for pwm_audio_dac: measures pwm_o high time, underrun pulses and
// handshake activity per carrier period against hand-computed expectations.
module tb_pwm_audio_dac;
    localparam int SAMPLE_W = 16;
    // A narrower carrier keeps the full ramp sequences short.
    localparam int PWM_BITS = 6;
    localparam int PER      = 1 << PWM_BITS;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [SAMPLE_W-1:0] l_i = '0;
    logic [SAMPLE_W-1:0] r_i = '0;
    logic                sample_valid = 1'b0;
    logic                sample_ready;
    logic                mute = 1'b0;
    logic                pwm_o;
    logic                active;
    logic                underrun;

    int checks = 0;
    int errors = 0;
    int mcnt = 0;

    pwm_audio_dac #(.SAMPLE_W(SAMPLE_W), .PWM_BITS(PWM_BITS)) dut (
        .clk(clk), .reset(reset), .l_i(l_i), .r_i(r_i),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .mute(mute), .pwm_o(pwm_o), .active(active), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Reference carrier position, tracked independently of the DUT.
    always @(posedge clk) mcnt <= reset ? 0 : (mcnt + 1) % PER;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One carrier period, sampled from cnt==1 through the following wrap.
    task automatic per(input string tag, input int send_at, input bit hold,
                       input logic [SAMPLE_W-1:0] l, input logic [SAMPLE_W-1:0] r,
                       input int e_hi, input int e_ur, input int e_acc, input int e_nr0);
        int hi, ur, acc, nr0;
        hi = 0; ur = 0; acc = 0; nr0 = 0;
        if (mcnt != 1) begin
            errors++;
            $display("FAIL %s_align: observed cnt %0d expected 1", tag, mcnt);
        end
        for (int i = 0; i < PER; i++) begin
            sample_valid = hold || (i == send_at);
            l_i = l;
            r_i = r;
            hi += int'(pwm_o);
            ur += int'(underrun);
            if (sample_valid && sample_ready) acc++;
            if (!sample_ready) nr0++;
            tick();
        end
        check({tag, "_hi"}, hi, e_hi);
        check({tag, "_ur"}, ur, e_ur);
        check({tag, "_acc"}, acc, e_acc);
        check({tag, "_nrdy"}, nr0, e_nr0);
    endtask

    initial begin
        int e;
        repeat (3) tick();
        check("rst_pwm", pwm_o, 0);
        check("rst_active", active, 0);
        check("rst_underrun", underrun, 0);
        check("rst_ready", sample_ready, 0);
        reset = 1'b0;
        tick();
        check("rel_ready", sample_ready, 1);
        check("rel_pwm", pwm_o, 0);

        // Ramp up from OFF: duty 0,0,1,...,32 then RUN.
        for (int k = 0; k <= 33; k++) begin
            e = (k < 2) ? 0 : k - 1;
            per($sformatf("ramp1_%0d", k), -1, 1'b0, '0, '0, e, 0, 0, 0);
            check($sformatf("ramp1_%0d_active", k), active, 32'(k == 33));
        end

        per("full_scale", 0, 1'b0, 16'h7FFF, 16'h7FFF, 32, 0, 1, 62);
        per("neg_scale",  0, 1'b0, 16'h8000, 16'h8000, 63, 0, 1, 62);
        per("mixed_zero", 0, 1'b0, 16'h7FFF, 16'h8000, 0, 0, 1, 62);
        per("hold_0", -1, 1'b0, '0, '0, 31, 1, 0, 0);
        per("hold_1", -1, 1'b0, '0, '0, 31, 1, 0, 0);
        per("hold_2", -1, 1'b0, '0, '0, 31, 1, 0, 0);
        // Accept exactly on the wrap cycle: consumed one wrap later.
        per("wrap_acc", PER - 2, 1'b0, 16'h4000, 16'h4000, 31, 1, 1, 1);
        per("wrap_wait", -1, 1'b0, '0, '0, 31, 0, 0, 63);
        per("wrap_load", -1, 1'b0, '0, '0, 48, 1, 0, 0);
        per("cont_0", -1, 1'b1, 16'h2000, 16'h2000, 48, 0, 2, 62);
        per("cont_1", -1, 1'b1, 16'h2000, 16'h2000, 40, 0, 1, 63);
        per("cont_end", -1, 1'b0, '0, '0, 40, 0, 0, 63);
        per("cont_ur", -1, 1'b0, '0, '0, 40, 1, 0, 0);
        check("run_active", active, 1);

        // Reset during RUN with a sample held.
        sample_valid = 1'b1;
        l_i = '0;
        r_i = '0;
        tick();
        sample_valid = 1'b0;
        check("pre_rst_ready", sample_ready, 0);
        check("pre_rst_pwm", pwm_o, 1);
        reset = 1'b1;
        tick();
        check("midrst_pwm", pwm_o, 0);
        check("midrst_active", active, 0);
        check("midrst_underrun", underrun, 0);
        check("midrst_ready", sample_ready, 0);
        reset = 1'b0;
        tick();
        check("midrel_ready", sample_ready, 1);
        check("midrel_active", active, 0);
        check("midrel_pwm", pwm_o, 0);

        // Ramp up again, play duty 50, mute down to OFF with an ignored unmute mid-ramp.
        for (int k = 0; k <= 90; k++) begin
            if (k == 35) mute = 1'b1;
            if (k == 60) mute = 1'b0;
            e = (k < 2) ? 0 : (k <= 33) ? k - 1 : (k == 34) ? 32 : (k <= 36) ? 50 :
                (k <= 86) ? 86 - k : (k <= 88) ? 0 : k - 88;
            per($sformatf("ramp2_%0d", k), (k == 34) ? 0 : -1, 1'b0, 16'h4800, 16'h4800,
                e, 0, (k == 34) ? 1 : 0, (k == 34) ? 62 : 0);
            check($sformatf("ramp2_%0d_active", k), active, 32'(k == 33 || k == 34));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
